// File: rtl/icache_refill_ctrl.sv
// Icache miss-refill sequencer: requests every word of the missing block, buffers
// out-of-order responses and writes them into the icache strictly in offset order.
module icache_refill_ctrl #(
  parameter int icache_tag_width_p           = 4,
  parameter int icache_entries_p             = 1024,
  parameter int icache_block_size_in_words_p = 4,
  localparam int pc_width_lp     = icache_tag_width_p + $clog2(icache_entries_p),
  localparam int offset_width_lp = $clog2(icache_block_size_in_words_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       miss_v_i,
  input  logic [pc_width_lp-1:0]     miss_pc_i,
  output logic                       miss_ready_o,
  output logic                       req_v_o,
  output logic [pc_width_lp-1:0]     req_pc_o,
  input  logic                       req_yumi_i,
  input  logic                       resp_v_i,
  input  logic [offset_width_lp-1:0] resp_offset_i,
  input  logic [31:0]                resp_instr_i,
  output logic                       icache_v_o,
  output logic [pc_width_lp-1:0]     icache_w_pc_o,
  output logic [31:0]                icache_w_instr_o,
  output logic                       done_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int n_lp = icache_block_size_in_words_p;
  localparam logic [pc_width_lp-1:0] base_mask_lp =
    {{(pc_width_lp-offset_width_lp){1'b1}}, {offset_width_lp{1'b0}}};
  localparam logic [offset_width_lp-1:0] last_off_lp = offset_width_lp'(n_lp - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e                     state_r;
  logic [pc_width_lp-1:0]     base_r;
  logic [offset_width_lp:0]   req_cnt_r;
  logic [offset_width_lp-1:0] wr_ptr_r;
  logic [n_lp-1:0]            valid_r;
  logic [31:0]                buf_r [n_lp];
  logic                       err_r;

  logic resp_dup, resp_accept, resp_err, wr_fire;

  always_comb begin
    // An offset below wr_ptr_r has already been written out to the icache.
    resp_dup    = valid_r[resp_offset_i] || (resp_offset_i < wr_ptr_r);
    resp_accept = resp_v_i && (state_r == FILL) && !resp_dup;
    resp_err    = resp_v_i && ((state_r != FILL) || resp_dup);
    wr_fire     = (state_r == FILL) && valid_r[wr_ptr_r];

    miss_ready_o     = (state_r == IDLE);
    busy_o           = (state_r != IDLE);
    done_o           = (state_r == DONE);
    err_o            = err_r;
    // Block size is a power of 2, so req_cnt_r < N is just a clear MSB.
    req_v_o          = (state_r == FILL) && !req_cnt_r[offset_width_lp];
    req_pc_o         = base_r | pc_width_lp'(req_cnt_r[offset_width_lp-1:0]);
    icache_v_o       = wr_fire;
    icache_w_pc_o    = base_r | pc_width_lp'(wr_ptr_r);
    icache_w_instr_o = buf_r[wr_ptr_r];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      base_r    <= '0;
      req_cnt_r <= '0;
      wr_ptr_r  <= '0;
      valid_r   <= '0;
      err_r     <= 1'b0;
    end else begin
      if (resp_err)
        err_r <= 1'b1;
      case (state_r)
        IDLE: if (miss_v_i) begin
          base_r    <= miss_pc_i & base_mask_lp;
          req_cnt_r <= '0;
          wr_ptr_r  <= '0;
          valid_r   <= '0;
          state_r   <= FILL;
        end
        FILL: begin
          if (req_v_o && req_yumi_i)
            req_cnt_r <= req_cnt_r + 1'b1;
          // Set and clear never target the same bit: a response to the drained
          // entry is a duplicate and is rejected by resp_dup.
          if (resp_accept)
            valid_r[resp_offset_i] <= 1'b1;
          if (wr_fire) begin
            valid_r[wr_ptr_r] <= 1'b0;
            wr_ptr_r          <= wr_ptr_r + 1'b1;
            if (wr_ptr_r == last_off_lp)
              state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (resp_accept)
      buf_r[resp_offset_i] <= resp_instr_i;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: directed refills push expected requests,
// writes and done pulses; a negedge monitor pops and compares them.
module tb_icache_refill_ctrl;
  localparam int TAG_W = 4, ENTRIES = 1024, N = 4, PC_W = 14, OFF_W = 2;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             miss_v_i, miss_ready_o, req_v_o, req_yumi_i, resp_v_i;
  logic [PC_W-1:0]  miss_pc_i, req_pc_o, icache_w_pc_o;
  logic [OFF_W-1:0] resp_offset_i;
  logic [31:0]      resp_instr_i, icache_w_instr_o;
  logic             icache_v_o, done_o, busy_o, err_o;

  icache_refill_ctrl #(
    .icache_tag_width_p(TAG_W),
    .icache_entries_p(ENTRIES),
    .icache_block_size_in_words_p(N)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .miss_v_i(miss_v_i), .miss_pc_i(miss_pc_i), .miss_ready_o(miss_ready_o),
    .req_v_o(req_v_o), .req_pc_o(req_pc_o), .req_yumi_i(req_yumi_i),
    .resp_v_i(resp_v_i), .resp_offset_i(resp_offset_i), .resp_instr_i(resp_instr_i),
    .icache_v_o(icache_v_o), .icache_w_pc_o(icache_w_pc_o),
    .icache_w_instr_o(icache_w_instr_o),
    .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [PC_W-1:0] pc; int c; } req_t;
  typedef struct { logic [PC_W-1:0] pc; logic [31:0] instr; int c; } wr_t;
  req_t req_q[$];
  wr_t  wr_q[$];
  int   done_q[$];

  int checks = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: unexpected output at cycle %0d (queue empty)", name, cyc);
  endtask

  // Monitor
  always @(negedge clk_i) begin
    if (reset_n_i === 1'b1) begin
      if (req_v_o) begin
        if (req_q.size() == 0) fail_now("req_unexpected");
        else begin
          check("req_pc", req_pc_o, req_q[0].pc);
          if (req_yumi_i) begin
            check("req_cycle", cyc, req_q[0].c);
            void'(req_q.pop_front());
          end
        end
      end
      if (icache_v_o) begin
        if (wr_q.size() == 0) fail_now("wr_unexpected");
        else begin
          check("wr_pc", icache_w_pc_o, wr_q[0].pc);
          check("wr_instr", icache_w_instr_o, wr_q[0].instr);
          check("wr_cycle", cyc, wr_q[0].c);
          void'(wr_q.pop_front());
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) fail_now("done_unexpected");
        else begin
          check("done_cycle", cyc, done_q[0]);
          void'(done_q.pop_front());
        end
      end
    end
  end

  // Per-cycle stimulus schedule
  logic             mv_a   [64];
  logic [PC_W-1:0]  mpc_a  [64];
  logic             yumi_a [64];
  logic             rv_a   [64];
  logic [OFF_W-1:0] roff_a [64];
  logic [31:0]      rd_a   [64];
  int pos;

  function automatic logic [31:0] data(input logic [PC_W-1:0] pc);
    return 32'hC0DE_0000 | 32'(pc);
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 64; i++) begin
      mv_a[i] = 1'b0; mpc_a[i] = '0; yumi_a[i] = 1'b0;
      rv_a[i] = 1'b0; roff_a[i] = '0; rd_a[i] = '0;
    end
    pos = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      miss_v_i = mv_a[pos]; miss_pc_i = mpc_a[pos]; req_yumi_i = yumi_a[pos];
      resp_v_i = rv_a[pos]; resp_offset_i = roff_a[pos]; resp_instr_i = rd_a[pos];
      pos++;
      @(posedge clk_i); #1;
    end
  endtask

  // Yumi held for four cycles from s+1, in-order responses one cycle later.
  task automatic sched_fill(input int s, input logic [PC_W-1:0] base);
    for (int i = 0; i < N; i++) begin
      yumi_a[s+1+i] = 1'b1;
      rv_a[s+2+i]   = 1'b1;
      roff_a[s+2+i] = OFF_W'(i);
      rd_a[s+2+i]   = data(base + PC_W'(i));
    end
  endtask

  // Expectations for an in-order best-case refill accepted at absolute cycle t.
  task automatic expect_fill(input int t, input logic [PC_W-1:0] base);
    for (int i = 0; i < N; i++) begin
      req_q.push_back('{base + PC_W'(i), t + 1 + i});
      wr_q.push_back('{base + PC_W'(i), data(base + PC_W'(i)), t + 3 + i});
    end
    done_q.push_back(t + 7);
  endtask

  task automatic do_reset();
    miss_v_i = 0; req_yumi_i = 0; resp_v_i = 0;
    reset_n_i = 1'b0;
    #3 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_miss_ready", miss_ready_o, 1);
    check("rst_req_v", req_v_o, 0);
    check("rst_icache_v", icache_v_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0;
  initial begin
    reset_n_i = 1'b0;
    miss_v_i = 0; miss_pc_i = '0; req_yumi_i = 0; resp_v_i = 0;
    resp_offset_i = '0; resp_instr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs();
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // In-order refill of 0x123
    clear_sched(); t0 = cyc;
    mv_a[0] = 1; mpc_a[0] = 14'h123;
    sched_fill(0, 14'h120);
    expect_fill(t0, 14'h120);
    run(8);
    check("t1_miss_ready_c8", miss_ready_o, 1);
    check("t1_err", err_o, 0);

    // Reversed responses: nothing written until offset 0 arrives
    clear_sched(); t0 = cyc;
    mv_a[0] = 1; mpc_a[0] = 14'h200;
    for (int i = 0; i < N; i++) begin
      yumi_a[1+i] = 1;
      req_q.push_back('{14'h200 + PC_W'(i), t0 + 1 + i});
      rv_a[5+i] = 1; roff_a[5+i] = OFF_W'(3 - i); rd_a[5+i] = data(14'h203 - PC_W'(i));
      wr_q.push_back('{14'h200 + PC_W'(i), data(14'h200 + PC_W'(i)), t0 + 9 + i});
    end
    done_q.push_back(t0 + 13);
    run(14);
    check("t2_miss_ready", miss_ready_o, 1);
    check("t2_err", err_o, 0);

    // Request backpressure: yumi alternates 0/1, req_pc must hold meanwhile
    clear_sched(); t0 = cyc;
    mv_a[0] = 1; mpc_a[0] = 14'h345;
    for (int i = 0; i < N; i++) begin
      yumi_a[2+2*i] = 1;
      req_q.push_back('{14'h344 + PC_W'(i), t0 + 2 + 2*i});
      rv_a[3+2*i] = 1; roff_a[3+2*i] = OFF_W'(i); rd_a[3+2*i] = data(14'h344 + PC_W'(i));
      wr_q.push_back('{14'h344 + PC_W'(i), data(14'h344 + PC_W'(i)), t0 + 4 + 2*i});
    end
    done_q.push_back(t0 + 11);
    run(12);
    check("t3_err", err_o, 0);

    // Response while IDLE: sticky error from the next cycle
    clear_sched();
    rv_a[0] = 1; roff_a[0] = 2'd2; rd_a[0] = 32'hDEAD_BEEF;
    run(1);
    check("t4_idle_err", err_o, 1);
    run(2);
    check("t4_idle_err_held", err_o, 1);
    do_reset();
    check("t4_err_cleared", err_o, 0);

    // Duplicate response to offset 1: error, first data kept
    clear_sched(); t0 = cyc;
    mv_a[0] = 1; mpc_a[0] = 14'h050;
    for (int i = 0; i < N; i++) begin
      yumi_a[1+i] = 1;
      req_q.push_back('{14'h050 + PC_W'(i), t0 + 1 + i});
    end
    rv_a[2] = 1; roff_a[2] = 0; rd_a[2] = data(14'h050);
    rv_a[3] = 1; roff_a[3] = 1; rd_a[3] = data(14'h051);
    rv_a[4] = 1; roff_a[4] = 1; rd_a[4] = 32'hBAD0_0051;
    rv_a[5] = 1; roff_a[5] = 2; rd_a[5] = data(14'h052);
    rv_a[6] = 1; roff_a[6] = 3; rd_a[6] = data(14'h053);
    wr_q.push_back('{14'h050, data(14'h050), t0 + 3});
    wr_q.push_back('{14'h051, data(14'h051), t0 + 4});
    wr_q.push_back('{14'h052, data(14'h052), t0 + 6});
    wr_q.push_back('{14'h053, data(14'h053), t0 + 7});
    done_q.push_back(t0 + 8);
    run(4);
    check("t4_dup_err_before", err_o, 0);
    run(1);
    check("t4_dup_err_after", err_o, 1);
    run(5);
    check("t4_dup_err_held", err_o, 1);
    check("t4_dup_miss_ready", miss_ready_o, 1);
    do_reset();

    // Reset mid-FILL after two writes, then a fresh refill from offset 0
    clear_sched(); t0 = cyc;
    mv_a[0] = 1; mpc_a[0] = 14'h3C0;
    sched_fill(0, 14'h3C0);
    for (int i = 0; i < N; i++) req_q.push_back('{14'h3C0 + PC_W'(i), t0 + 1 + i});
    wr_q.push_back('{14'h3C0, data(14'h3C0), t0 + 3});
    wr_q.push_back('{14'h3C1, data(14'h3C1), t0 + 4});
    run(5);
    miss_v_i = 0; req_yumi_i = 0; resp_v_i = 0;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs();
    #3 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    clear_sched(); t0 = cyc;
    mv_a[0] = 1; mpc_a[0] = 14'h3C2;
    sched_fill(0, 14'h3C0);
    expect_fill(t0, 14'h3C0);
    run(8);
    check("t5_err", err_o, 0);

    // Back-to-back misses with miss_v held high
    clear_sched(); t0 = cyc;
    for (int i = 0; i <= 8; i++) begin
      mv_a[i] = 1; mpc_a[i] = (i == 0) ? 14'h080 : 14'h0A7;
    end
    sched_fill(0, 14'h080);
    sched_fill(8, 14'h0A4);
    expect_fill(t0, 14'h080);
    expect_fill(t0 + 8, 14'h0A4);
    run(8);
    check("t6_ready_after_done", miss_ready_o, 1);
    run(9);
    check("t6_miss_ready_end", miss_ready_o, 1);
    check("t6_err", err_o, 0);

    check("req_q_empty", req_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
